// File: rtl/div_ctrl_pkg.sv
// Shared CPU definitions used by the divide sequencer and the execute stage.
// Holds the ALU op codes for the HI/LO producers, the HI/LO width and the
// sequencer state encoding, plus a small magnitude helper for signed operands.
package div_ctrl_pkg;

   localparam logic [7:0] EXE_MULT_OP = 8'h14;
   localparam logic [7:0] EXE_DIV_OP  = 8'h16;
   localparam logic [7:0] EXE_DIVU_OP = 8'h17;

   localparam int HILO_W = 64;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DIVZ = 2'b10,
      S_DONE = 2'b11
   } div_state_e;

   // Two's-complement magnitude when the operand is treated as signed.
   // 0x8000_0000 maps onto itself, which the unsigned datapath reads as 2^31.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divide sequencer sitting beside execute.
// Ports: clk/rst_n; div_start_i, div_signed_i, dividend_i, divisor_i and
// cancel_i from execute; stall_o to the front of the pipe; ready_o + hilo_o
// ({HI = remainder, LO = quotient}) valid for one cycle in DONE.
// Latency: accept edge, DIV_ITER busy cycles, one DONE cycle (divide-by-zero
// takes a single DIVZ cycle instead). Result outputs are decoded from
// registers only.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                div_start_i,
   input  logic                div_signed_i,
   input  logic [31:0]         dividend_i,
   input  logic [31:0]         divisor_i,
   input  logic                cancel_i,
   output logic                stall_o,
   output logic                ready_o,
   output logic [HILO_W-1:0]   hilo_o
);

   localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // {R[31:0], Q[31:0]}. R is always below the divisor between steps, so the
   // 33rd remainder bit only exists transiently inside the shifted value.
   logic [63:0]        rq_q, rq_d;
   logic [31:0]        dvs_q, dvs_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;

   logic               accept;
   logic               last_iter;
   logic [64:0]        shifted;
   logic [32:0]        trial;
   logic [31:0]        rem_mag;
   logic [31:0]        quo_mag;

   assign accept    = (state_q == S_IDLE) && div_start_i && !cancel_i;
   assign last_iter = (cnt_q == CNT_W'(DIV_ITER - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      if (cancel_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (div_start_i) state_d = (divisor_i == 32'd0) ? S_DIVZ : S_BUSY;
            S_BUSY: if (last_iter)   state_d = S_DONE;
            S_DIVZ:                  state_d = S_DONE;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign rem_mag = rq_q[63:32];
   assign quo_mag = rq_q[31:0];

   always_comb begin
      // Reset must hold the pipeline free even if execute is requesting.
      stall_o = rst_n && (accept || (state_q == S_BUSY) || (state_q == S_DIVZ));
      ready_o = (state_q == S_DONE);
      hilo_o  = '0;
      if (state_q == S_DONE) begin
         hilo_o = {negr_q ? (~rem_mag + 32'd1) : rem_mag,
                   negq_q ? (~quo_mag + 32'd1) : quo_mag};
      end
   end

   // ---------------- datapath ----------------
   // One restoring step: shift, trial-subtract, keep the trial if it stayed
   // non-negative and record a 1 in the quotient.
   assign shifted = {rq_q, 1'b0};
   assign trial   = shifted[64:32] - {1'b0, dvs_q};

   always_comb begin
      cnt_d  = cnt_q;
      rq_d   = rq_q;
      dvs_d  = dvs_q;
      negq_d = negq_q;
      negr_d = negr_q;
      if (accept) begin
         cnt_d = '0;
         if (divisor_i == 32'd0) begin
            // Preload the fixed divide-by-zero answer; no sign correction.
            rq_d   = {dividend_i, 32'hFFFF_FFFF};
            dvs_d  = '0;
            negq_d = 1'b0;
            negr_d = 1'b0;
         end else begin
            rq_d   = {32'd0, mag32(dividend_i, div_signed_i)};
            dvs_d  = mag32(divisor_i, div_signed_i);
            negq_d = div_signed_i && (dividend_i[31] ^ divisor_i[31]);
            negr_d = div_signed_i && dividend_i[31];
         end
      end else if (state_q == S_BUSY) begin
         cnt_d = cnt_q + CNT_W'(1);
         rq_d  = trial[32] ? shifted[63:0] : {trial[31:0], shifted[31:1], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         rq_q   <= '0;
         dvs_q  <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rq_q   <= rq_d;
         dvs_q  <= dvs_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer beside the execute stage. It accepts DIV/DIVU operands from execute and stalls the pipeline while a 32-iteration restoring division runs. It then presents a 64-bit HI/LO result for one cycle so execute can forward it down the HI/LO write path. It also handles divide-by-zero and pipeline flush.

## Interface
- `DIV_ITER`, default 32: number of quotient bits; one bit is produced per cycle.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `div_start_i`  in  1  execute holds a DIV/DIVU; stays high until `ready_o`.
- `div_signed_i`  in  1  1 = DIV (signed), 0 = DIVU.
- `dividend_i`  in  32  execute src1; sampled at accept.
- `divisor_i`  in  32  execute src2; sampled at accept.
- `cancel_i`  in  1  pipeline flush; aborts any operation.
- `stall_o`  out  1  freezes the PC, IF/ID and ID/EXE registers.
- `ready_o`  out  1  one-cycle pulse; `hilo_o` is valid.
- `hilo_o`  out  64  {HI = remainder, LO = quotient}; 0 when not ready.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: iterating, counter 0..DIV_ITER-1.
  - DIVZ: divisor is zero.
  - DONE: result presented.
- Accept: in IDLE, `div_start_i` high and `cancel_i` low.
  - Latch the operand magnitudes. When signed, negate negative operands in two's complement.
  - Latch `neg_q` = sign(dividend) XOR sign(divisor), and `neg_r` = sign(dividend).
  - Go to DIVZ if the divisor is 0, otherwise to BUSY.
- BUSY iteration, on a 65-bit partial-remainder/quotient register {R[32:0], Q[31:0]}:
  - Shift left by 1.
  - Trial = R − {1'b0, |divisor|}.
  - If the trial is non-negative, R = trial and Q[0] = 1.
  - After DIV_ITER iterations, go to DONE.
- DIVZ: go to DONE after one cycle. The result is quotient 0xFFFF_FFFF and remainder = the original (unnegated) dividend_i.
- DONE:
  - `ready_o` = 1.
  - `hilo_o` = {neg_r ? −R : R, neg_q ? −Q : Q}. Signed correction applies only when `div_signed_i` was latched as 1.
  - Always return to IDLE next edge, whatever `div_start_i` is.
- `stall_o` = (IDLE & div_start_i & ~cancel_i) | BUSY | DIVZ. It is combinational and low in DONE, so the pipeline advances on the DONE edge.
- `cancel_i` in any state: next state is IDLE and `ready_o` does not pulse. `cancel_i` has priority over accept.
- 0x8000_0000 / −1 signed: the magnitude path yields quotient 0x8000_0000 and remainder 0. No trap.
- Asynchronous reset, also valid mid-operation:
  - state = IDLE, counter = 0, datapath registers = 0.
  - `ready_o` = 0 and `hilo_o` = 0.
  - `stall_o` = 0 for as long as `rst_n` is low.

## Timing
- Accept edge at cycle 0. BUSY occupies cycles 1..32 and DONE is cycle 33. `ready_o` is high during cycle 33.
- `stall_o` is high in cycles 0..32, i.e. 33 stall cycles.
- Divide-by-zero: accept at cycle 0, DIVZ in cycle 1, DONE in cycle 2, 2 stall cycles.
- Back-to-back divides: the earliest next accept is the cycle after DONE.
- `hilo_o` and `ready_o` are registered, decoded from the DONE state plus registered data. No combinational path from the inputs.
- Operands are sampled only at accept. Changes to `dividend_i` or `divisor_i` during BUSY are ignored.

## Structure
- Shared CPU package holds:
  - ALU op codes `EXE_DIV_OP` = 8'h16 and `EXE_DIVU_OP` = 8'h17, alongside the existing MULT 8'h14.
  - State encoding constants: IDLE=2'b00, BUSY=2'b01, DIVZ=2'b10, DONE=2'b11.
  - HI/LO width 64.
- Execute stage decodes the op code into `div_start_i` and `div_signed_i`. When `ready_o` is high it selects `hilo_o` over the MULT result for `exe_hilo_o`.
- Single module, no sub-module. An optional `div_iter` cell (one restoring step, combinational) may be factored out for readability.

## Test plan
- DIVU 100 / 7 → `stall_o` high for 33 cycles, then `ready_o` in cycle 33 with LO = 14, HI = 2.
- DIV −7 (0xFFFF_FFF9) / 2 → LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1).
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0; DIVU 0xFFFF_FFFF / 1 → LO = 0xFFFF_FFFF, HI = 0.
- DIVU 5 / 0 → `ready_o` in cycle 2 with LO = 0xFFFF_FFFF, HI = 5; `stall_o` high for exactly 2 cycles.
- `cancel_i` at BUSY cycle 10 → IDLE next edge, no `ready_o`, `stall_o` low. A new DIVU 9 / 3 accepted the following cycle yields LO = 3, HI = 0.
- `rst_n` low at BUSY cycle 20 → all outputs 0 immediately. After release, 1 idle cycle, then DIVU 1 / 1 → LO = 1, HI = 0.
